// File: rtl/keyboard_sync_filter_pkg.sv
// Shared limits and helpers for the keyboard-side input conditioning blocks.
package keyboard_pkg;

    localparam int KBD_SYNC_STAGES_MIN = 2;
    localparam int KBD_SYNC_STAGES_MAX = 4;
    localparam int KBD_FILTER_MAX      = 255;

    // Stability counter width: enough to count to P_FILTER-1, never below one bit.
    function automatic int kbd_cnt_width(input int filter);
        int w;
        w = $clog2(filter);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/keyboard_sync_filter_ch.sv
// One conditioned channel: synchronizer chain, sample-gated stability filter,
// registered filtered level and registered rise/fall strobes.
module keyboard_sync_filter_ch
    import keyboard_pkg::*;
#(
    parameter int   P_STAGES = 2,
    parameter int   P_FILTER = 4,
    parameter logic P_INIT   = 1'b1
) (
    input  logic iCLOCK,
    input  logic iRESET,
    input  logic iRESET_SYNC,
    input  logic iSAMPLE_EN,
    input  logic iDATA,
    output logic oDATA,
    output logic oRISE,
    output logic oFALL
);

    localparam int               CNT_W    = kbd_cnt_width(P_FILTER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_FILTER - 1);

    logic [P_STAGES-1:0] sync_r;
    logic                sync_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic                level_r;
    logic                level_s;
    logic                rise_r;
    logic                rise_s;
    logic                fall_r;
    logic                fall_s;

    assign sync_s = sync_r[P_STAGES-1];

    // Filter next state: a change is accepted only after P_FILTER consecutive differing samples.
    always_comb begin
        cnt_s   = cnt_r;
        level_s = level_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        if (iSAMPLE_EN) begin
            if (sync_s == level_r) begin
                cnt_s = {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                cnt_s   = {CNT_W{1'b0}};
                level_s = sync_s;
                rise_s  = sync_s;
                fall_s  = ~sync_s;
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s   = cnt_r;
            level_s = level_r;
        end
    end

    // State registers; both resets return to the idle level without strobing.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            sync_r  <= {P_STAGES{P_INIT}};
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= P_INIT;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else if (iRESET_SYNC) begin
            sync_r  <= {P_STAGES{P_INIT}};
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= P_INIT;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[P_STAGES-2:0], iDATA};
            cnt_r   <= cnt_s;
            level_r <= level_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
        end
    end

    assign oDATA = level_r;
    assign oRISE = rise_r;
    assign oFALL = fall_r;

endmodule

// File: rtl/keyboard_sync_filter.sv
// Multi-channel conditioner for asynchronous keyboard-side pins (e.g. PS/2 clock/data):
// independent synchronize-then-filter channels with per-channel edge strobes.
module keyboard_sync_filter
    import keyboard_pkg::*;
#(
    parameter int             P_N      = 2,
    parameter int             P_STAGES = 2,
    parameter int             P_FILTER = 4,
    parameter logic [P_N-1:0] P_INIT   = {P_N{1'b1}}
) (
    input  logic           iCLOCK,
    input  logic           iRESET,
    input  logic           iRESET_SYNC,
    input  logic           iSAMPLE_EN,
    input  logic [P_N-1:0] iDATA,
    output logic [P_N-1:0] oDATA,
    output logic [P_N-1:0] oRISE,
    output logic [P_N-1:0] oFALL
);

    if ((P_STAGES < KBD_SYNC_STAGES_MIN) || (P_STAGES > KBD_SYNC_STAGES_MAX)) begin : g_bad_stages
        $error("keyboard_sync_filter: P_STAGES=%0d outside %0d..%0d",
               P_STAGES, KBD_SYNC_STAGES_MIN, KBD_SYNC_STAGES_MAX);
    end

    if ((P_FILTER < 1) || (P_FILTER > KBD_FILTER_MAX)) begin : g_bad_filter
        $error("keyboard_sync_filter: P_FILTER=%0d outside 1..%0d", P_FILTER, KBD_FILTER_MAX);
    end

    for (genvar i = 0; i < P_N; i++) begin : g_ch
        keyboard_sync_filter_ch #(
            .P_STAGES (P_STAGES),
            .P_FILTER (P_FILTER),
            .P_INIT   (P_INIT[i])
        ) u_ch (
            .iCLOCK      (iCLOCK),
            .iRESET      (iRESET),
            .iRESET_SYNC (iRESET_SYNC),
            .iSAMPLE_EN  (iSAMPLE_EN),
            .iDATA       (iDATA[i]),
            .oDATA       (oDATA[i]),
            .oRISE       (oRISE[i]),
            .oFALL       (oFALL[i])
        );
    end

endmodule

// File: doc/keyboard_sync_filter.md
Name: keyboard_sync_filter

Overview:
Parametrised multi-channel input conditioner for keyboard-side asynchronous signals, such as PS/2 clock and data.
- Each channel passes through a configurable-depth synchronizer chain, then a sample-gated glitch filter (stability counter).
- Registered rise/fall strobes are generated per channel.
- Sits between the device pins and the keyboard protocol receiver, and replaces the fixed two-flop synchronizer.

Parameters:
P_N, 2, number of independent channels.
P_STAGES, 2, synchronizer flop depth; legal range 2..4.
P_FILTER, 4, consecutive differing samples required before the filtered output changes; legal range 1..255.
P_INIT, {P_N{1'b1}}, reset value of the synchronizer chain and the filtered output (PS/2 idles high).

Ports:
iCLOCK  input  1  system clock; the only clock.
iRESET  input  1  asynchronous active-high reset.
iRESET_SYNC  input  1  synchronous clear; same effect as iRESET, applied on a clock edge.
iSAMPLE_EN  input  1  filter sample strobe from a prescaler; tie to 1 for every-cycle sampling.
iDATA  input  P_N  asynchronous raw inputs.
oDATA  output  P_N  synchronized, filtered levels.
oRISE  output  P_N  one-cycle strobe: oDATA bit went 0->1 this cycle.
oFALL  output  P_N  one-cycle strobe: oDATA bit went 1->0 this cycle.

Behaviour:
Clock and reset: one clock; reset is asynchronous and active-high.
- Priority: iRESET > iRESET_SYNC > normal operation.

Reset state (both resets):
- All synchronizer stages = P_INIT.
- oDATA = P_INIT.
- All counters = 0.
- oRISE = 0, oFALL = 0.

Synchronizer:
- Shifts on every clock, regardless of iSAMPLE_EN.
- s = last stage; iDATA reaches s after exactly P_STAGES edges.

Per-channel filter, evaluated on edges where iSAMPLE_EN=1:
- If s == oDATA: cnt <= 0.
- Else if cnt == P_FILTER-1: oDATA <= s and cnt <= 0.
- Else: cnt <= cnt+1.

Filter with iSAMPLE_EN=0:
- cnt and oDATA hold.
- oRISE/oFALL are 0.

Counter rules:
- Width is clog2(P_FILTER) bits, minimum 1; it never wraps.
- Any sample where s matches oDATA clears the count, so a glitch shorter than P_FILTER samples never propagates.

Latency (iSAMPLE_EN=1, clean input step at edge 0):
- oDATA changes at edge P_STAGES+P_FILTER.
- With P_FILTER=1, latency is P_STAGES+1.

Strobes:
- Registered; asserted in the same cycle oDATA changes and deasserted the next cycle.
- oRISE[i] and oFALL[i] are never both 1.
- No strobes are generated by reset or by leaving reset.

Channels are fully independent; simultaneous changes on several channels produce simultaneous strobes.

Reset mid-count: the count is discarded, and oDATA returns to P_INIT with no strobe.

If iRESET_SYNC and iSAMPLE_EN are asserted together, iRESET_SYNC wins.

Decomposition:
Shared package keyboard_pkg holds:
- KBD_SYNC_STAGES_MIN = 2 and KBD_SYNC_STAGES_MAX = 4.
- KBD_FILTER_MAX = 255.
- Function kbd_cnt_width(P_FILTER), returning max(1, clog2(P_FILTER)).

Elaboration-time assertions check P_STAGES and P_FILTER against these limits.

One sub-module, keyboard_sync_filter_ch:
- Contains a single channel's chain, counter, output flop and strobe flops.
- Instantiated P_N times by a generate loop in the top module.

Test Plan:
1. Reset: hold iRESET=1 with iDATA=2'b00, then release -> oDATA=2'b11, oRISE=oFALL=0 during reset and for the entire first cycle after release.
2. Latency: defaults, iSAMPLE_EN=1, iDATA[0] 1->0 at edge 0 -> oDATA[0]=0 and oFALL[0]=1 for exactly one cycle at edge 6; oDATA[1] stays 1 with no strobe on channel 1.
3. Glitch rejection: iDATA[0] pulses low for 3 cycles, P_FILTER=4 -> no oDATA change and no strobes; a 4-cycle low pulse -> oFALL[0] at edge 6, then oRISE[0] 4 cycles later.
4. Sample gating: iSAMPLE_EN=1 every 4th cycle, step on iDATA[1] -> oDATA[1] changes only after 4 enabled samples, about 16 cycles after the synchronizer delay; the count holds across disabled cycles.
5. Sync clear mid-count: assert iRESET_SYNC with cnt=2 -> next edge: oDATA=P_INIT, cnt=0, no strobe; the filter then restarts a full P_FILTER-sample count.
6. Parameter corners: P_FILTER=1, P_STAGES=3, P_N=8, all inputs toggled together -> all 8 strobes fire in the same cycle at edge 4, with oRISE and oFALL never both set on any bit.
